// File: rtl/gate_array_filtered.sv
// gate_array_filtered: CHANNELS independent INPUTS-wide gates with an
// elaboration-time function, a sample register, and a per-channel stability
// filter that moves y only after FILTER_CYCLES consecutive differing samples.
module gate_array_filtered #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned MODE          = 0,
  parameter int unsigned FILTER_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CHANNELS*INPUTS-1:0]   din,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          y_change
);

  localparam int unsigned    CW       = $clog2(FILTER_CYCLES + 1);
  // Gate value with all inputs low; r and y both reset here so release is quiet.
  localparam logic           REST     = (MODE == 1) || (MODE == 3);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  if (MODE > 4) begin : g_bad_mode
    $error("gate_array_filtered: MODE must be 0..4");
  end

  logic [CHANNELS-1:0] g;
  logic [CHANNELS-1:0] r_q, r_d;
  logic [CHANNELS-1:0] y_q, y_d;
  logic [CHANNELS-1:0] chg_q, chg_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  // Combinational gate function per channel.
  always_comb begin
    g = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      case (MODE)
        0:       g[c] =  (&din[c*INPUTS +: INPUTS]);
        1:       g[c] = ~(&din[c*INPUTS +: INPUTS]);
        2:       g[c] =  (|din[c*INPUTS +: INPUTS]);
        3:       g[c] = ~(|din[c*INPUTS +: INPUTS]);
        4:       g[c] =  (^din[c*INPUTS +: INPUTS]);
        default: g[c] = 1'b0;
      endcase
    end
  end

  // Next-state: sample register and stability filter; en=0 freezes all but the pulse.
  always_comb begin
    r_d   = r_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    chg_d = '0;
    if (en) begin
      r_d = g;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (r_q[c] == y_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          y_d[c]   = r_q[c];
          cnt_d[c] = '0;
          chg_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset to REST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= {CHANNELS{REST}};
      y_q   <= {CHANNELS{REST}};
      chg_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      r_q   <= r_d;
      y_q   <= y_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign y        = y_q;
  assign y_change = chg_q;

endmodule

// File: tb/tb_gate_array_filtered.sv
// Directed bench for gate_array_filtered: several parameterisations share one
// clock and are exercised one after another from a single initial block.
module tb_gate_array_filtered;

  logic clk;
  logic rst_n, rst_e;
  logic en, en_d;
  logic [7:0]  din_a, din_b, din_c, din_d, din_e;
  logic [11:0] din_f;
  logic [1:0]  y_a, yc_a, y_b, yc_b, y_c, yc_c, y_d, yc_d, y_e, yc_e;
  logic [3:0]  y_f, yc_f;

  int checks = 0;
  int errors = 0;

  // NAND, reset behaviour
  gate_array_filtered #(.CHANNELS(2), .INPUTS(4), .MODE(1), .FILTER_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a), .y(y_a), .y_change(yc_a));
  // AND, minimum filter
  gate_array_filtered #(.CHANNELS(2), .INPUTS(4), .MODE(0), .FILTER_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b), .y(y_b), .y_change(yc_b));
  // OR, glitch rejection
  gate_array_filtered #(.CHANNELS(2), .INPUTS(4), .MODE(2), .FILTER_CYCLES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_c), .y(y_c), .y_change(yc_c));
  // AND, enable stall
  gate_array_filtered #(.CHANNELS(2), .INPUTS(4), .MODE(0), .FILTER_CYCLES(3)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en_d), .din(din_d), .y(y_d), .y_change(yc_d));
  // NAND, reset mid-count
  gate_array_filtered #(.CHANNELS(2), .INPUTS(4), .MODE(1), .FILTER_CYCLES(8)) u_e (
    .clk(clk), .rst_n(rst_e), .en(en), .din(din_e), .y(y_e), .y_change(yc_e));
  // XOR, random against reference
  gate_array_filtered #(.CHANNELS(4), .INPUTS(3), .MODE(4), .FILTER_CYCLES(2)) u_f (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_f), .y(y_f), .y_change(yc_f));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  mr, my, mchg;
  int unsigned mcnt [4];
  logic        gbit;

  initial begin
    rst_n = 1'b0; rst_e = 1'b0; en = 1'b1; en_d = 1'b1;
    din_a = 8'h00; din_b = 8'h70; din_c = 8'h00; din_d = 8'h00; din_e = 8'h00;
    din_f = '0;
    tick(); tick();
    chk("rst_a_y",   32'(y_a),  32'h3);
    chk("rst_a_chg", 32'(yc_a), 32'h0);
    chk("rst_b_y",   32'(y_b),  32'h0);
    chk("rst_e_y",   32'(y_e),  32'h3);
    chk("rst_f_y",   32'(y_f),  32'h0);
    @(negedge clk);
    rst_n = 1'b1; rst_e = 1'b1;

    // NAND with all-zero inputs: y stays at REST, no pulse after release
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_a_y",   32'(y_a),  32'h3);
      chk("post_rst_a_chg", 32'(yc_a), 32'h0);
    end

    // AND, FILTER_CYCLES=1: channel 0 rises with latency 2 edges
    din_b = 8'h7F;
    tick();
    chk("and_e0_y",   32'(y_b),  32'h0);
    chk("and_e0_chg", 32'(yc_b), 32'h0);
    tick();
    chk("and_e1_y",   32'(y_b),  32'h1);
    chk("and_e1_chg", 32'(yc_b), 32'h1);
    tick();
    chk("and_e2_y",   32'(y_b),  32'h1);
    chk("and_e2_chg", 32'(yc_b), 32'h0);

    // OR, FILTER_CYCLES=4: a 3-cycle pulse is rejected
    for (int i = 0; i < 8; i++) begin
      din_c = (i < 3) ? 8'h01 : 8'h00;
      tick();
      chk("glitch_y",   32'(y_c),  32'h0);
      chk("glitch_chg", 32'(yc_c), 32'h0);
    end
    // 4-cycle pulse passes at E0+4
    for (int i = 0; i < 6; i++) begin
      din_c = (i < 4) ? 8'h01 : 8'h00;
      tick();
      chk("pass_y",   32'(y_c),  (i >= 4) ? 32'h1 : 32'h0);
      chk("pass_chg", 32'(yc_c), (i == 4) ? 32'h1 : 32'h0);
    end

    // Enable stall, FILTER_CYCLES=3: count survives en=0
    din_d = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pre_y", 32'(y_d), 32'h0);
    end
    en_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_off_y",   32'(y_d),  32'h0);
      chk("stall_off_chg", 32'(yc_d), 32'h0);
    end
    en_d = 1'b1;
    tick();
    chk("stall_resume_y",   32'(y_d),  32'h1);
    chk("stall_resume_chg", 32'(yc_d), 32'h1);
    en_d = 1'b0;
    tick();
    chk("stall_pulse_clr_y",   32'(y_d),  32'h1);
    chk("stall_pulse_clr_chg", 32'(yc_d), 32'h0);
    en_d = 1'b1;

    // NAND, FILTER_CYCLES=8: bring channel 1 away from REST first
    din_e = 8'hF0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("e_ch1_y",   32'(y_e),  (i == 8) ? 32'h1 : 32'h3);
      chk("e_ch1_chg", 32'(yc_e), (i == 8) ? 32'h2 : 32'h0);
    end
    // channel 0 counts to 5, then reset lands between edges
    din_e = 8'hFF;
    for (int i = 0; i < 6; i++) tick();
    chk("e_midcount_y", 32'(y_e), 32'h1);
    #2 rst_e = 1'b0;
    #1;
    chk("e_async_rst_y",   32'(y_e),  32'h3);
    chk("e_async_rst_chg", 32'(yc_e), 32'h0);
    @(negedge clk);
    rst_e = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("e_restart_y",   32'(y_e),  (i == 8) ? 32'h0 : 32'h3);
      chk("e_restart_chg", 32'(yc_e), (i == 8) ? 32'h3 : 32'h0);
    end

    // XOR, 4 channels x 3 inputs, random din/en against a reference model
    mr = '0; my = '0; mchg = '0;
    for (int c = 0; c < 4; c++) mcnt[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      din_f = 12'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 4; c++) begin
        if (en) begin
          gbit = ^din_f[c*3 +: 3];
          if (mr[c] != my[c]) begin
            if (mcnt[c] == 1) begin
              my[c] = mr[c]; mcnt[c] = 0; mchg[c] = 1'b1;
            end else begin
              mcnt[c] = mcnt[c] + 1; mchg[c] = 1'b0;
            end
          end else begin
            mcnt[c] = 0; mchg[c] = 1'b0;
          end
          mr[c] = gbit;
        end else begin
          mchg[c] = 1'b0;
        end
      end
      tick();
      chk("xor_y",   32'(y_f),  32'(my));
      chk("xor_chg", 32'(yc_f), 32'(mchg));
    end
    en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
